// File: rtl/fsk_demod.sv
// fsk_demod: zero-crossing FSK demodulator.
// A 2-level polarity tracker with hysteresis finds zero crossings, the
// half-period length decides the tone, and a symbol counter aligned to
// tone changes emits one recovered bit per SYM_LEN valid samples.
// Optional feature macro: FSK_DEMOD_GLITCH_FILTER_EN (tone change needs two
// consecutive differing estimates). Default build: single estimate suffices.
module fsk_demod #(
  parameter int HYST    = 16,
  parameter int HALF_TH = 64,
  parameter int SYM_LEN = 1024,
  parameter int TIMEOUT = 511
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       tone,
  output logic       locked
);

  localparam logic [1:0]  ST_HUNT  = 2'd0;
  localparam logic [1:0]  ST_SYNC  = 2'd1;
  localparam logic [1:0]  ST_TRACK = 2'd2;

  localparam logic [8:0]  POS_TH   = 9'(128 + HYST);
  localparam logic [8:0]  NEG_TH   = 9'(128 - HYST);
  localparam logic [9:0]  TO_VAL   = 10'(TIMEOUT);
  localparam logic [10:0] HALF_V   = 11'(HALF_TH);
  localparam logic [11:0] SYM_HALF = 12'(SYM_LEN / 2 - 1);
  localparam logic [11:0] SYM_FULL = 12'(SYM_LEN - 1);

  logic [1:0]  state_r,     state_n;
  logic        pol_r,       pol_n;
  logic        pol_known_r, pol_known_n;
  logic [9:0]  half_cnt_r,  half_cnt_n;
  logic [11:0] sym_cnt_r,   sym_cnt_n;
  logic        tone_r,      tone_n;
  logic        bit_out_r,   bit_out_n;
  logic        bit_valid_r, bit_valid_n;
  logic        locked_r,    locked_n;

  logic        is_pos_s, is_neg_s, crossing_s, est_s, timeout_s, accept_s;
  logic [10:0] meas_s;

  assign is_pos_s   = ({1'b0, din} >= POS_TH);
  assign is_neg_s   = ({1'b0, din} <= NEG_TH);
  // A crossing is a confirmed polarity flip; midscale samples never flip.
  assign crossing_s = din_valid & pol_known_r & (is_pos_s | is_neg_s) & (is_pos_s != pol_r);
  assign meas_s     = {1'b0, half_cnt_r} + 11'd1;
  assign est_s      = (meas_s <= HALF_V);
  assign timeout_s  = din_valid & (half_cnt_r == TO_VAL) & (state_r != ST_HUNT);

`ifdef FSK_DEMOD_GLITCH_FILTER_EN
  logic pend_r;
  assign accept_s = crossing_s & (est_s != tone_r) & pend_r;

  // Remember one differing estimate; a second consecutive one is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= 1'b0;
    end else if (din_valid) begin
      if ((state_r == ST_TRACK) && crossing_s && (est_s != tone_r) && !pend_r) begin
        pend_r <= 1'b1;
      end else if ((state_r != ST_TRACK) || crossing_s) begin
        pend_r <= 1'b0;
      end else begin
        pend_r <= pend_r;
      end
    end else begin
      pend_r <= pend_r;
    end
  end
`else
  assign accept_s = crossing_s & (est_s != tone_r);
`endif

  // Next-state logic: polarity, half-period counter, FSM and symbol timing.
  always_comb begin
    state_n     = state_r;
    pol_n       = pol_r;
    pol_known_n = pol_known_r;
    half_cnt_n  = half_cnt_r;
    sym_cnt_n   = sym_cnt_r;
    tone_n      = tone_r;
    bit_out_n   = bit_out_r;
    bit_valid_n = 1'b0;
    if (din_valid) begin
      if (is_pos_s | is_neg_s) begin
        pol_n       = is_pos_s;
        pol_known_n = 1'b1;
      end else begin
        pol_n       = pol_r;
      end
      if (crossing_s) begin
        half_cnt_n = 10'd0;
      end else if (half_cnt_r != TO_VAL) begin
        half_cnt_n = half_cnt_r + 10'd1;
      end else begin
        half_cnt_n = half_cnt_r;
      end
      case (state_r)
        ST_HUNT: begin
          // First crossing closes a partial interval: discard it.
          if (crossing_s) begin
            state_n = ST_SYNC;
          end else begin
            state_n = ST_HUNT;
          end
        end
        ST_SYNC: begin
          if (crossing_s) begin
            state_n   = ST_TRACK;
            tone_n    = est_s;
            sym_cnt_n = SYM_HALF;
          end else if (timeout_s) begin
            state_n     = ST_HUNT;
            pol_known_n = 1'b0;
          end else begin
            state_n = ST_SYNC;
          end
        end
        ST_TRACK: begin
          // Tone change resyncs to mid-symbol and suppresses a coincident bit.
          if (accept_s) begin
            tone_n    = est_s;
            sym_cnt_n = SYM_HALF;
          end else if (timeout_s && !crossing_s) begin
            state_n     = ST_HUNT;
            pol_known_n = 1'b0;
          end else if (sym_cnt_r == 12'd0) begin
            bit_out_n   = tone_r;
            bit_valid_n = 1'b1;
            sym_cnt_n   = SYM_FULL;
          end else begin
            sym_cnt_n = sym_cnt_r - 12'd1;
          end
        end
        default: begin
          state_n = ST_HUNT;
        end
      endcase
    end else begin
      state_n = state_r;
    end
    locked_n = (state_n == ST_TRACK);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_HUNT;
      pol_r       <= 1'b0;
      pol_known_r <= 1'b0;
      half_cnt_r  <= 10'd0;
      sym_cnt_r   <= 12'd0;
      tone_r      <= 1'b0;
      bit_out_r   <= 1'b0;
      bit_valid_r <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_n;
      pol_r       <= pol_n;
      pol_known_r <= pol_known_n;
      half_cnt_r  <= half_cnt_n;
      sym_cnt_r   <= sym_cnt_n;
      tone_r      <= tone_n;
      bit_out_r   <= bit_out_n;
      bit_valid_r <= bit_valid_n;
      locked_r    <= locked_n;
    end
  end

  assign bit_out   = bit_out_r;
  assign bit_valid = bit_valid_r;
  assign tone      = tone_r;
  assign locked    = locked_r;

endmodule

// File: tb/tb_fsk_demod.sv
// tb_fsk_demod: directed, table-driven bench for fsk_demod.
// Stimulus is a square wave (half-period hp samples) or a midscale hold;
// each table row drives one segment and states the expected outputs.
module tb_fsk_demod;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       bit_out, bit_valid, tone, locked;

  int n_tests = 0;
  int n_fail  = 0;

  logic       gen_lvl;
  int         gen_cnt;
  logic [7:0] hi_lvl;
  logic [7:0] lo_lvl;

  typedef struct {
    int hp;       // half-period in samples, 0 = hold midscale
    int len;      // samples in segment
    bit restart;  // start a fresh half-period at the segment start
    int pulses;   // expected bit_valid pulses in segment
    bit pbit;     // expected bit_out on each pulse
    bit tone;     // expected tone at segment end
    bit locked;   // expected locked at segment end
    bit bout;     // expected bit_out at segment end
  } seg_t;

  seg_t segs[14];

  fsk_demod dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .bit_out(bit_out), .bit_valid(bit_valid), .tone(tone), .locked(locked)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic v);
    @(negedge clk);
    din       = d;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic run_seg(input int hp, input int len, input bit restart,
                         input bit toggle, input bit pbit, output int npulse);
    logic [7:0] d;
    npulse = 0;
    if (restart) gen_cnt = hp;
    for (int i = 0; i < len; i++) begin
      if (hp == 0) begin
        d = 8'd128;
      end else begin
        if (gen_cnt >= hp) begin
          gen_lvl = ~gen_lvl;
          gen_cnt = 1;
        end else begin
          gen_cnt++;
        end
        d = gen_lvl ? hi_lvl : lo_lvl;
      end
      if (toggle) begin
        drive(d, 1'b0);
        check("no pulse on invalid", int'(bit_valid), 0);
      end
      drive(d, 1'b1);
      if (bit_valid) begin
        npulse++;
        check("pulse bit", int'(bit_out), int'(pbit));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din       = 8'd128;
    #1;
    check("rst bit_out", int'(bit_out), 0);
    check("rst bit_valid", int'(bit_valid), 0);
    check("rst tone", int'(tone), 0);
    check("rst locked", int'(locked), 0);
    @(negedge clk);
    rst_n   = 1'b1;
    gen_lvl = 1'b0;
    gen_cnt = 0;
  endtask

  initial begin
    int np;
    rst_n     = 1'b0;
    din       = 8'd128;
    din_valid = 1'b0;
    hi_lvl    = 8'd200;
    lo_lvl    = 8'd56;
    gen_lvl   = 1'b0;
    gen_cnt   = 0;

    //          hp   len   rst pulses pbit tone lock bout
    segs[0]  = '{128,  256, 1, 0, 0, 0, 0, 0};  // HUNT -> SYNC, not yet locked
    segs[1]  = '{128, 1792, 0, 2, 0, 0, 1, 0};  // lock at 256, bits at 768, 1792
    segs[2]  = '{16,  1024, 1, 1, 1, 1, 1, 1};  // high tone, resync mid-symbol
    segs[3]  = '{16,  1024, 0, 1, 1, 1, 1, 1};
    segs[4]  = '{128, 1024, 1, 1, 0, 0, 1, 0};  // back to low tone
    segs[5]  = '{128, 1024, 0, 1, 0, 0, 1, 0};
    segs[6]  = '{16,  1024, 1, 1, 1, 1, 1, 1};
    segs[7]  = '{0,    496, 0, 0, 0, 1, 1, 1};  // midscale: one sample before timeout
    segs[8]  = '{0,      1, 0, 0, 0, 1, 0, 1};  // timeout: unlock, bit_out holds
    segs[9]  = '{128,  512, 1, 0, 0, 0, 1, 1};  // relock from HUNT
    segs[10] = '{20,    20, 1, 0, 0, 0, 1, 1};  // 20-sample glitch half-period
`ifdef FSK_DEMOD_GLITCH_FILTER_EN
    segs[11] = '{128,    1, 1, 0, 0, 0, 1, 1};  // isolated estimate ignored
`else
    segs[11] = '{128,    1, 1, 0, 0, 1, 1, 1};  // glitch flips tone to 1
`endif
    segs[12] = '{128,  128, 0, 0, 0, 0, 1, 1};  // tone back to 0
    segs[13] = '{128,  640, 0, 1, 0, 0, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    check("init bit_out", int'(bit_out), 0);
    check("init bit_valid", int'(bit_valid), 0);
    check("init tone", int'(tone), 0);
    check("init locked", int'(locked), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_seg(segs[i].hp, segs[i].len, segs[i].restart, 1'b0, segs[i].pbit, np);
      check($sformatf("seg%0d pulses", i), np, segs[i].pulses);
      check($sformatf("seg%0d tone", i), int'(tone), int'(segs[i].tone));
      check($sformatf("seg%0d locked", i), int'(locked), int'(segs[i].locked));
      check($sformatf("seg%0d bit_out", i), int'(bit_out), int'(segs[i].bout));
    end

    // Reset mid-TRACK, then relock with din_valid toggling every cycle.
    do_reset();
    check("post-rst locked", int'(locked), 0);
    run_seg(128, 1900, 1'b1, 1'b1, 1'b0, np);
    check("toggle pulses", np, 2);
    check("toggle locked", int'(locked), 1);
    check("toggle tone", int'(tone), 0);
    check("toggle bit_out", int'(bit_out), 0);

    // Hysteresis edges: 144/112 classify, lock after exactly 257 samples.
    do_reset();
    hi_lvl = 8'd144;
    lo_lvl = 8'd112;
    run_seg(128, 256, 1'b1, 1'b0, 1'b0, np);
    check("hyst edge pre-lock", int'(locked), 0);
    run_seg(128, 1, 1'b0, 1'b0, 1'b0, np);
    check("hyst edge lock", int'(locked), 1);

    // Just inside the dead band: 143/113 never classify, never lock.
    do_reset();
    hi_lvl = 8'd143;
    lo_lvl = 8'd113;
    run_seg(128, 400, 1'b1, 1'b0, 1'b0, np);
    check("hyst inside locked", int'(locked), 0);
    check("hyst inside pulses", np, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
